// File: rtl/gray_to_binary_pipe.sv
// Two-stage Gray-to-binary decoder with valid/ready flow control.
// Flags input steps of more than one bit and counts them in a saturating counter.
module gray_to_binary_pipe #(
  parameter int VEC_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [VEC_W-1:0] gray_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [VEC_W-1:0] bin_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             step_err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [VEC_W-1:0] VEC_ONE = VEC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [VEC_W-1:0] gray_to_bin(input logic [VEC_W-1:0] g);
    logic [VEC_W-1:0] b;
    b[VEC_W-1] = g[VEC_W-1];
    for (int k = VEC_W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Stage 1 state plus the step-check history
  logic             r_s1_vld;
  logic [VEC_W-1:0] r_s1_gray;
  logic             r_s1_err;
  logic [VEC_W-1:0] r_prev_gray;
  logic             r_prev_vld;

  // Stage 2 state drives the outputs directly
  logic             r_s2_vld;
  logic [VEC_W-1:0] r_s2_bin;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [VEC_W-1:0] w_diff;
  logic             w_step_err;
  logic [VEC_W-1:0] w_s1_bin;

  assign w_s2_adv = !r_s2_vld || ready_i;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  // Gated by rst_ni so nothing is accepted while the block is held in reset.
  assign ready_o  = rst_ni && w_s1_adv;
  assign w_accept = valid_i && ready_o;

  // More than one bit set in the difference <=> clearing the lowest set bit leaves a non-zero word.
  assign w_diff     = gray_i ^ r_prev_gray;
  assign w_step_err = r_prev_vld && ((w_diff & (w_diff - VEC_ONE)) != '0);
  assign w_s1_bin   = gray_to_bin(r_s1_gray);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld    <= 1'b0;
      r_s1_gray   <= '0;
      r_s1_err    <= 1'b0;
      r_prev_gray <= '0;
      r_prev_vld  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= w_accept;
      end
      if (w_accept) begin
        r_s1_gray   <= gray_i;
        r_s1_err    <= w_step_err;
        r_prev_gray <= gray_i;
        r_prev_vld  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_vld  <= 1'b0;
      r_s2_bin  <= '0;
      r_s2_err  <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_bin <= w_s1_bin;
        r_s2_err <= r_s1_err;
        if (r_s1_err && (r_err_cnt != CNT_MAX)) begin
          r_err_cnt <= r_err_cnt + CNT_ONE;
        end
      end
    end
  end

  assign valid_o    = r_s2_vld;
  assign bin_o      = r_s2_bin;
  assign step_err_o = r_s2_err;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: doc/gray_to_binary_pipe.md
# gray_to_binary_pipe

Pipelined Gray-to-binary decoder with valid/ready flow control and step checking. It is the receive-side counterpart of the binary-to-Gray encoder. It accepts Gray-coded values (counter pointers, encoder positions) one per cycle, returns the binary value two cycles later, and flags any input pair that is not a legal single-step Gray transition. It sits between a Gray-coded source and binary consumers (comparators, address logic) and tolerates consumer backpressure without dropping or duplicating data.

## Interface
- VEC_W, 4, width of the Gray input and binary output (legal range 2..32)
- CNT_W, 8, width of the saturating error counter
- clk_i  input  1  clock; all state changes on the rising edge
- rst_ni  input  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to clk_i externally
- gray_i  input  VEC_W  Gray-coded input word
- valid_i  input  1  gray_i is valid this cycle
- ready_o  output  1  block can accept gray_i this cycle
- bin_o  output  VEC_W  decoded binary word
- valid_o  output  1  bin_o and step_err_o are valid
- ready_i  input  1  consumer accepts the output this cycle
- step_err_o  output  1  the current output beat's input differed from the previous accepted input in more than one bit
- err_cnt_o  output  CNT_W  count of step errors since reset; saturates at all-ones

## Operation
- Decode rule:
  - bin[VEC_W-1] = gray[VEC_W-1]
  - bin[k] = bin[k+1] XOR gray[k], for k = VEC_W-2 down to 0
- Input handshake: a beat is accepted when valid_i && ready_o.
- Output handshake: a beat is consumed when valid_o && ready_i.
- Stage 1 (S1):
  - Registers the accepted gray_i.
  - Computes the Hamming distance to prev_gray, the last accepted input.
  - Registers err1 = (prev_vld && distance > 1).
  - On accept, updates prev_gray <= gray_i and sets prev_vld <= 1.
- Stage 2 (S2):
  - Registers the decoded binary word of S1 together with err1.
  - Drives bin_o, step_err_o and valid_o directly from flops.
- Step-check rules:
  - Distance 0 (repeated code) is legal.
  - Distance 1 is legal in either direction.
  - The first accepted beat after reset is never flagged.
  - Wrap-around is legal, e.g. 1000 -> 0000 for VEC_W = 4.
- Error counter:
  - err_cnt_o increments by 1 when a beat with err1 = 1 moves from S1 into S2.
  - It holds at 2^CNT_W - 1 once saturated.
- Flow control:
  - S2 advances when !valid_o || ready_i.
  - S1 advances when S1 is empty or S2 advances.
  - ready_o = S1 empty or S2 advances. This is combinational from ready_i, so there is no bubble and throughput is 1 beat per cycle.
- While valid_o && !ready_i:
  - bin_o, step_err_o and valid_o hold stable.
  - S1 holds its content.
  - ready_o is low only if S1 is also full.
- No beat is dropped, duplicated or reordered.

## Timing
- Reset values (rst_ni low):
  - valid_o = 0, bin_o = 0, step_err_o = 0, err_cnt_o = 0, ready_o = 0.
  - S1 valid = 0, prev_gray = 0, prev_vld = 0.
- ready_o is 1 in the first cycle after rst_ni deasserts.
- Latency: a beat accepted at edge N appears on valid_o/bin_o after edge N+1, i.e. 2 cycles, when ready_i is held high.
- Full pipeline with ready_i low: at most 2 beats are buffered, one in S1 and one in S2.
- Simultaneous output consume and input accept in the same cycle: both occur; the pipeline shifts by one.
- Reset mid-operation:
  - All in-flight beats are discarded.
  - prev_vld clears, so the next accepted beat is unflagged.
  - The error counter clears.
- Backpressure does not alter step checking: comparison is against the previous accepted input, not the previous consumed output.

## Test plan
- Exhaustive sweep, VEC_W = 4, ready_i = 1:
  - Stimulus: feed Gray codes of 0..15 back-to-back, then 0 again (wrap 1000 -> 0000).
  - Required: bin_o = 0..15, 0 in order, each 2 cycles after its input; step_err_o = 0 throughout; err_cnt_o = 0.
- Illegal step:
  - Stimulus: feed 0000, 0001, 0111.
  - Required: bin_o = 0000, 0001, 0101; step_err_o = 0, 0, 1; err_cnt_o = 1 after the third beat reaches S2.
- Backpressure:
  - Stimulus: stream Gray 0..7 while ready_i toggles 1, 0, 0, 1 repeating.
  - Required: ready_o drops only when both stages are full; bin_o holds while stalled; the output sequence is exactly 0..7 with no gaps or repeats.
- Repeat and first-beat exemption:
  - Stimulus: after reset, feed 1111, 1111, 1110.
  - Required: bin_o = 1010, 1010, 1011; step_err_o = 0 on all beats.
- Reset mid-stream:
  - Stimulus: stream with both stages full, pulse rst_ni low for 1 cycle, then feed 0110.
  - Required: during reset valid_o = 0, ready_o = 0, err_cnt_o = 0; afterwards bin_o = 0100 with step_err_o = 0.
- Counter saturation:
  - Parameters: CNT_W = 2.
  - Stimulus: alternate 0000 and 0011 for 6 beats.
  - Required: err_cnt_o reads 1, 2, 3, 3, 3 on the flagged beats.
